// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction prefetch with PC-tagged FIFO, valid/ready output and redirect flush
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] fetch_pc, inflight_pc;
  logic        inflight, pop, push;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] credit;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic        unused_low_bits;
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign out_valid_o = (count != '0) & ~redirect_i;
  assign pop = out_valid_o & out_ready_i;
  assign push = inflight & ~redirect_i;
  assign credit = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
  assign imem_req_o = ~rst_i & ~redirect_i & (credit < (AW+2)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign out_instr_o = (count != '0) ? instr_mem[rd_ptr] : '0;
  assign out_pc_o = (count != '0) ? pc_mem[rd_ptr] : '0;
  // fetch pointer, in-flight tracking and FIFO bookkeeping; redirect flushes everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // the returning word lands at the tail tagged with the PC it was fetched from
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr] <= inflight_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch, backpressure, redirect, wrap and async reset
module tb_instr_fetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0, rst = 1'b1, req, redirect = 1'b0, valid, ready = 1'b1;
  logic [31:0] addr, rdata = '0, redirect_pc = '0, instr, pc;
  int checks = 0, failures = 0;
  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .out_valid_o(valid), .out_ready_i(ready),
    .out_instr_o(instr), .out_pc_o(pc)
  );
  always #5 clk = ~clk;
  // instruction memory: word returned one cycle after the request
  always @(posedge clk) rdata <= req ? (addr ^ K) : '0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("c0_req", 32'(req), 1);
    chk("c0_addr", addr, 32'h0);
    step();
    chk("c1_req", 32'(req), 1);
    chk("c1_addr", addr, 32'h4);
    chk("c1_valid", 32'(valid), 0);
    step();
    chk("c2_valid", 32'(valid), 1);
    chk("c2_pc", pc, 32'h0);
    chk("c2_instr", instr, K);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("stream_valid", 32'(valid), 1);
      chk("stream_pc", pc, 32'(4 * i));
      chk("stream_instr", instr, 32'(4 * i) ^ K);
    end
    rst = 1'b1;
    ready = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_pc", pc, 0);
    chk("arst_instr", instr, 0);
    chk("arst_req", 32'(req), 0);
    step();
    rst = 1'b0;
    #1;
    chk("bp_c0_addr", addr, 32'h0);
    step();
    chk("bp_c1_addr", addr, 32'h4);
    step();
    chk("bp_c2_addr", addr, 32'h8);
    chk("bp_c2_valid", 32'(valid), 1);
    chk("bp_c2_pc", pc, 32'h0);
    step();
    chk("bp_c3_req", 32'(req), 1);
    chk("bp_c3_addr", addr, 32'hC);
    step();
    chk("bp_c4_req", 32'(req), 0);
    step();
    chk("bp_c5_req", 32'(req), 0);
    chk("bp_c5_pc", pc, 32'h0);
    ready = 1'b1;
    #1;
    chk("bp_pop_req", 32'(req), 1);
    chk("bp_pop_addr", addr, 32'h10);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("bp_drain_pc", pc, 32'(4 * i));
      chk("bp_drain_valid", 32'(valid), 1);
    end
    rst = 1'b1;
    ready = 1'b0;
    #1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    step();
    chk("rd_pre_valid", 32'(valid), 1);
    chk("rd_pre_req", 32'(req), 0);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_r_valid", 32'(valid), 0);
    chk("rd_r_req", 32'(req), 0);
    step();
    redirect = 1'b0;
    #1;
    chk("rd_r1_req", 32'(req), 1);
    chk("rd_r1_addr", addr, 32'h40);
    chk("rd_r1_valid", 32'(valid), 0);
    step();
    chk("rd_r2_valid", 32'(valid), 0);
    step();
    chk("rd_r3_valid", 32'(valid), 1);
    chk("rd_r3_pc", pc, 32'h40);
    chk("rd_r3_instr", instr, 32'h40 ^ K);
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h43;
    #1;
    chk("rdr_valid", 32'(valid), 0);
    chk("rdr_req", 32'(req), 0);
    step();
    redirect = 1'b0;
    #1;
    chk("rdr_addr", addr, 32'h40);
    step();
    step();
    chk("rdr_pc0", pc, 32'h40);
    step();
    chk("rdr_pc1", pc, 32'h44);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    #1;
    chk("b2b_addr", addr, 32'h200);
    step();
    step();
    chk("b2b_pc", pc, 32'h200);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_a0", addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_a1", addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_a2", addr, 32'h0);
    chk("wrap_pc0", pc, 32'hFFFF_FFF8);
    chk("wrap_i0", instr, 32'h5A5A_FFF8);
    step();
    chk("wrap_pc1", pc, 32'hFFFF_FFFC);
    chk("wrap_i1", instr, 32'h5A5A_FFFC);
    step();
    chk("wrap_pc2", pc, 32'h0);
    chk("wrap_i2", instr, K);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
